// File: rtl/zw_pkg.sv
// Shared constants, error codes, FSM state type and checksum helper for the
// fingerprint-module reply parser.
package zw_pkg;

  localparam logic [7:0] ZW_HDR_H   = 8'hEF;
  localparam logic [7:0] ZW_HDR_L   = 8'h01;
  localparam logic [7:0] ZW_PID_ACK = 8'h07;
  localparam logic [7:0] ZW_PID_END = 8'h08;

  localparam logic [2:0] ZW_ERR_NONE    = 3'd0;
  localparam logic [2:0] ZW_ERR_ADDR    = 3'd1;
  localparam logic [2:0] ZW_ERR_PID     = 3'd2;
  localparam logic [2:0] ZW_ERR_LEN     = 3'd3;
  localparam logic [2:0] ZW_ERR_SUM     = 3'd4;
  localparam logic [2:0] ZW_ERR_TIMEOUT = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_H2    = 4'd1,
    ST_ADDR  = 4'd2,
    ST_PID   = 4'd3,
    ST_LEN_H = 4'd4,
    ST_LEN_L = 4'd5,
    ST_BODY  = 4'd6,
    ST_SUM_H = 4'd7,
    ST_SUM_L = 4'd8
  } zw_state_e;

  // Packet checksum accumulates PID, length and body bytes modulo 2^16.
  function automatic logic [15:0] zw_sum_add(input logic [15:0] sum, input logic [7:0] b);
    return sum + {8'h00, b};
  endfunction

endpackage

// File: rtl/zw_ack_rx_parser_if.sv
// Byte-stream input and parsed-packet result bundle of the reply parser.
interface zw_ack_rx_parser_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [7:0] param_data;
  logic       param_valid;
  logic [7:0] confirm_code;
  logic       pkt_done;
  logic       pkt_ok;
  logic [2:0] err_code;

  modport master (
    output rx_data, rx_valid,
    input  busy, param_data, param_valid, confirm_code, pkt_done, pkt_ok, err_code
  );

  modport slave (
    input  rx_data, rx_valid,
    output busy, param_data, param_valid, confirm_code, pkt_done, pkt_ok, err_code
  );

endinterface

// File: rtl/zw_ack_rx_parser_timeout.sv
// Inter-byte timeout counter for the reply parser; present only when the
// parser is built with ZW_RX_TIMEOUT_EN.
module zw_rx_timeout #(
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  logic [CW-1:0] cnt_r;

  // Counts idle cycles inside a packet; any received byte restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear || !run) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A byte in the expiry cycle wins, so clear masks the flag.
  assign expired = run && !clear && (cnt_r == CNT_LAST);

endmodule

// File: rtl/zw_ack_rx_parser.sv
// Fingerprint-module reply parser: frames EF01/addr/PID/len/body/checksum and
// reports confirm code, parameter bytes and status. Option: ZW_RX_TIMEOUT_EN.
module zw_ack_rx_parser
  import zw_pkg::*;
#(
  parameter logic [31:0] MOD_ADDR    = 32'hFFFF_FFFF,
  parameter int          MAX_BODY    = 16,
  parameter int          TIMEOUT_CYC = 2_500_000
) (
  input logic               clk,
  input logic               rst_n,
  zw_ack_rx_parser_if.slave bus
);

  localparam int              BCW        = $clog2(MAX_BODY + 1);
  localparam logic [15:0]     MAX_BODY_W = 16'(MAX_BODY);
  localparam logic [BCW-1:0]  BODY_ONE   = BCW'(32'd1);

  zw_state_e      state_r;
  logic           busy_r;
  logic [7:0]     param_data_r;
  logic           param_valid_r;
  logic [7:0]     confirm_r;
  logic           pkt_done_r;
  logic           pkt_ok_r;
  logic [2:0]     err_r;
  logic [23:0]    addr_r;
  logic [1:0]     addr_cnt_r;
  logic [7:0]     len_hi_r;
  logic [15:0]    sum_r;
  logic [7:0]     sum_hi_r;
  logic [BCW-1:0] body_cnt_r;
  logic           first_body_r;

  logic [15:0]    len_s;
  logic [15:0]    len_body_s;
  logic           len_bad_s;
  logic           timeout_exp_s;

  assign len_s      = {len_hi_r, bus.rx_data};
  assign len_body_s = len_s - 16'd2;
  assign len_bad_s  = (len_s < 16'd3) || (len_body_s > MAX_BODY_W);

`ifdef ZW_RX_TIMEOUT_EN
  zw_rx_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.rx_valid),
    .run     (state_r != ST_IDLE),
    .expired (timeout_exp_s)
  );
`else
  assign timeout_exp_s = 1'b0;
  if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
  end
`endif

  // Packet framing FSM; every output is a register updated on byte arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      param_data_r  <= 8'h00;
      param_valid_r <= 1'b0;
      confirm_r     <= 8'h00;
      pkt_done_r    <= 1'b0;
      pkt_ok_r      <= 1'b0;
      err_r         <= ZW_ERR_NONE;
      addr_r        <= 24'h000000;
      addr_cnt_r    <= 2'd0;
      len_hi_r      <= 8'h00;
      sum_r         <= 16'h0000;
      sum_hi_r      <= 8'h00;
      body_cnt_r    <= '0;
      first_body_r  <= 1'b0;
    end else begin
      pkt_done_r    <= 1'b0;
      param_valid_r <= 1'b0;
      if (bus.rx_valid) begin
        case (state_r)
          ST_IDLE: begin
            if (bus.rx_data == ZW_HDR_H) begin
              state_r <= ST_H2;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_H2: begin
            if (bus.rx_data == ZW_HDR_L) begin
              state_r    <= ST_ADDR;
              addr_cnt_r <= 2'd0;
            end else if (bus.rx_data == ZW_HDR_H) begin
              state_r <= ST_H2;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
          ST_ADDR: begin
            addr_r     <= {addr_r[15:0], bus.rx_data};
            addr_cnt_r <= addr_cnt_r + 2'd1;
            if (addr_cnt_r != 2'd3) begin
              state_r <= ST_ADDR;
            end else if ({addr_r, bus.rx_data} == MOD_ADDR) begin
              state_r <= ST_PID;
            end else begin
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              pkt_done_r <= 1'b1;
              pkt_ok_r   <= 1'b0;
              err_r      <= ZW_ERR_ADDR;
            end
          end
          ST_PID: begin
            if (bus.rx_data == ZW_PID_ACK || bus.rx_data == ZW_PID_END) begin
              state_r <= ST_LEN_H;
              sum_r   <= {8'h00, bus.rx_data};
            end else begin
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              pkt_done_r <= 1'b1;
              pkt_ok_r   <= 1'b0;
              err_r      <= ZW_ERR_PID;
            end
          end
          ST_LEN_H: begin
            len_hi_r <= bus.rx_data;
            sum_r    <= zw_sum_add(sum_r, bus.rx_data);
            state_r  <= ST_LEN_L;
          end
          ST_LEN_L: begin
            sum_r <= zw_sum_add(sum_r, bus.rx_data);
            if (len_bad_s) begin
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              pkt_done_r <= 1'b1;
              pkt_ok_r   <= 1'b0;
              err_r      <= ZW_ERR_LEN;
            end else begin
              state_r      <= ST_BODY;
              body_cnt_r   <= len_body_s[BCW-1:0];
              first_body_r <= 1'b1;
            end
          end
          ST_BODY: begin
            sum_r      <= zw_sum_add(sum_r, bus.rx_data);
            body_cnt_r <= body_cnt_r - BODY_ONE;
            if (first_body_r) begin
              confirm_r    <= bus.rx_data;
              first_body_r <= 1'b0;
            end else begin
              param_data_r  <= bus.rx_data;
              param_valid_r <= 1'b1;
            end
            if (body_cnt_r == BODY_ONE) begin
              state_r <= ST_SUM_H;
            end else begin
              state_r <= ST_BODY;
            end
          end
          ST_SUM_H: begin
            sum_hi_r <= bus.rx_data;
            state_r  <= ST_SUM_L;
          end
          ST_SUM_L: begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            pkt_done_r <= 1'b1;
            if ({sum_hi_r, bus.rx_data} == sum_r) begin
              pkt_ok_r <= 1'b1;
              err_r    <= ZW_ERR_NONE;
            end else begin
              pkt_ok_r <= 1'b0;
              err_r    <= ZW_ERR_SUM;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end else if (timeout_exp_s) begin
        state_r    <= ST_IDLE;
        busy_r     <= 1'b0;
        pkt_done_r <= 1'b1;
        pkt_ok_r   <= 1'b0;
        err_r      <= ZW_ERR_TIMEOUT;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.busy         = busy_r;
  assign bus.param_data   = param_data_r;
  assign bus.param_valid  = param_valid_r;
  assign bus.confirm_code = confirm_r;
  assign bus.pkt_done     = pkt_done_r;
  assign bus.pkt_ok       = pkt_ok_r;
  assign bus.err_code     = err_r;

endmodule

// File: tb/tb_zw_ack_rx_parser.sv
// Table-driven bench for zw_ack_rx_parser plus hand sequences for reset,
// resync, back-to-back packets and the optional timeout (ZW_RX_TIMEOUT_EN).
module tb_zw_ack_rx_parser;

  logic clk;
  logic rst_n;
  zw_ack_rx_parser_if zif ();

  zw_ack_rx_parser #(
    .MOD_ADDR    (32'hFFFF_FFFF),
    .MAX_BODY    (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (zif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] data;
    int           n;
    logic         ok;
    logic [2:0]   err;
    logic [7:0]   conf;
    int           np;
    logic [31:0]  pword;
    int           done_at;
  } vec_t;

  vec_t vecs [11];

  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  time last_t = 0;
  byte unsigned tx_q [$];

  // Monitor state (written only by the monitor process)
  int          done_cnt = 0;
  int          ok_cnt = 0;
  int          np_cnt = 0;
  logic [31:0] pword = 32'h0;
  logic        last_ok = 1'b0;
  logic [2:0]  last_err = 3'd0;
  int          done_at = 0;
  time         done_t = 0;

  always @(negedge clk) begin
    if (zif.param_valid) begin
      np_cnt <= np_cnt + 1;
      pword  <= {pword[23:0], zif.param_data};
    end
    if (zif.pkt_done) begin
      done_cnt <= done_cnt + 1;
      ok_cnt   <= ok_cnt + (zif.pkt_ok ? 1 : 0);
      last_ok  <= zif.pkt_ok;
      last_err <= zif.err_code;
      done_at  <= sent_cnt;
      done_t   <= $time;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input logic [127:0] d, input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(d[127-8*i -: 8]);
  endtask

  // Sends the queue; burst=1 means one byte per cycle, else one idle cycle between bytes.
  task automatic send_q(input bit burst);
    while (tx_q.size() > 0) begin
      zif.rx_data  = tx_q.pop_front();
      zif.rx_valid = 1'b1;
      sent_cnt++;
      @(posedge clk);
      last_t = $time;
      #1;
      if (!burst || tx_q.size() == 0) begin
        zif.rx_valid = 1'b0;
        zif.rx_data  = 8'h00;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, zif.busy}, 32'd0);
    chk({tag, "_pv"},    {31'd0, zif.param_valid}, 32'd0);
    chk({tag, "_pd"},    {24'd0, zif.param_data}, 32'd0);
    chk({tag, "_conf"},  {24'd0, zif.confirm_code}, 32'd0);
    chk({tag, "_done"},  {31'd0, zif.pkt_done}, 32'd0);
    chk({tag, "_ok"},    {31'd0, zif.pkt_ok}, 32'd0);
    chk({tag, "_err"},   {29'd0, zif.err_code}, 32'd0);
  endtask

  localparam logic [127:0] PKT_GOOD = 128'hEF01_FFFF_FFFF_0700_0300_000A_0000_0000;
  localparam logic [127:0] PKT_C21  = 128'hEF01_FFFF_FFFF_0700_0321_002B_0000_0000;
  localparam logic [127:0] PKT_END  = 128'hEF01_FFFF_FFFF_0800_0300_000B_0000_0000;

  initial begin
    int d0, ok0, np0, s0;
    logic [31:0] mask;

    vecs[0]  = '{"good_ack", PKT_GOOD, 12, 1'b1, 3'd0, 8'h00, 0, 32'h0, 12};
    vecs[1]  = '{"params", 128'hEF01_FFFF_FFFF_0700_0700_0005_0064_0077, 16, 1'b1, 3'd0, 8'h00, 4, 32'h0005_0064, 16};
    vecs[2]  = '{"bad_sum", 128'hEF01_FFFF_FFFF_0700_0300_000B_0000_0000, 12, 1'b0, 3'd4, 8'h00, 0, 32'h0, 12};
    vecs[3]  = '{"conf21", PKT_C21, 12, 1'b1, 3'd0, 8'h21, 0, 32'h0, 12};
    vecs[4]  = '{"bad_addr", 128'hEF01_1234_5678_0000_0000_0000_0000_0000, 6, 1'b0, 3'd1, 8'h21, 0, 32'h0, 6};
    vecs[5]  = '{"bad_pid", 128'hEF01_FFFF_FFFF_0900_0000_0000_0000_0000, 7, 1'b0, 3'd2, 8'h21, 0, 32'h0, 7};
    vecs[6]  = '{"len_2", 128'hEF01_FFFF_FFFF_0700_0200_0000_0000_0000, 9, 1'b0, 3'd3, 8'h21, 0, 32'h0, 9};
    vecs[7]  = '{"len_13", 128'hEF01_FFFF_FFFF_0700_1300_0000_0000_0000, 9, 1'b0, 3'd3, 8'h21, 0, 32'h0, 9};
    vecs[8]  = '{"resync", 128'h33EF_EF01_FFFF_FFFF_0700_0300_000A_0000, 14, 1'b1, 3'd0, 8'h00, 0, 32'h0, 14};
    vecs[9]  = '{"end_pid", PKT_END, 12, 1'b1, 3'd0, 8'h00, 0, 32'h0, 12};
    vecs[10] = '{"carry", 128'hEF01_FFFF_FFFF_0700_0600_FFFF_FF03_0A00, 15, 1'b1, 3'd0, 8'h00, 3, 32'h00FF_FFFF, 15};

    rst_n = 1'b0;
    zif.rx_data  = 8'h00;
    zif.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 11; v++) begin
      d0 = done_cnt; np0 = np_cnt; s0 = sent_cnt;
      load_vec(vecs[v].data, vecs[v].n);
      send_q(1'b0);
      idle(3);
      mask = (vecs[v].np >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * vecs[v].np)) - 32'h1);
      chk({vecs[v].name, "_done_cnt"}, done_cnt - d0, 32'd1);
      chk({vecs[v].name, "_ok"},       {31'd0, last_ok}, {31'd0, vecs[v].ok});
      chk({vecs[v].name, "_err"},      {29'd0, last_err}, {29'd0, vecs[v].err});
      chk({vecs[v].name, "_done_at"},  done_at - s0, vecs[v].done_at);
      chk({vecs[v].name, "_np"},       np_cnt - np0, vecs[v].np);
      chk({vecs[v].name, "_pword"},    pword & mask, vecs[v].pword);
      chk({vecs[v].name, "_conf"},     {24'd0, zif.confirm_code}, {24'd0, vecs[v].conf});
      chk({vecs[v].name, "_busy"},     {31'd0, zif.busy}, 32'd0);
    end

    // EF then a non-header byte: silent return to IDLE
    d0 = done_cnt;
    tx_q.push_back(8'hEF);
    send_q(1'b0);
    chk("h2_busy_set", {31'd0, zif.busy}, 32'd1);
    tx_q.push_back(8'h55);
    send_q(1'b0);
    idle(2);
    chk("h2_busy_clr", {31'd0, zif.busy}, 32'd0);
    chk("h2_no_done", done_cnt - d0, 32'd0);

    // Two packets back to back, one byte per cycle
    d0 = done_cnt; ok0 = ok_cnt; s0 = sent_cnt;
    load_vec(PKT_GOOD, 12);
    load_vec(PKT_END, 12);
    send_q(1'b1);
    idle(3);
    chk("b2b_done_cnt", done_cnt - d0, 32'd2);
    chk("b2b_ok_cnt", ok_cnt - ok0, 32'd2);
    chk("b2b_done_at", done_at - s0, 32'd24);

    // Mid-packet reset clears everything and emits no pkt_done
    load_vec(PKT_C21, 12);
    send_q(1'b0);
    idle(2);
    chk("rst_pre_conf", {24'd0, zif.confirm_code}, 32'h21);
    d0 = done_cnt;
    load_vec(PKT_GOOD, 7);
    send_q(1'b0);
    chk("rst_pre_busy", {31'd0, zif.busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk_outputs_zero("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    ok0 = ok_cnt;
    load_vec(PKT_GOOD, 12);
    send_q(1'b0);
    idle(3);
    chk("midrst_after_ok", ok_cnt - ok0, 32'd1);
    chk("midrst_after_done", done_cnt - d0, 32'd1);

    // Stall after LEN_H
    d0 = done_cnt;
    load_vec(PKT_GOOD, 8);
    send_q(1'b0);
`ifdef ZW_RX_TIMEOUT_EN
    idle(120);
    chk("to_done_cnt", done_cnt - d0, 32'd1);
    chk("to_ok", {31'd0, last_ok}, 32'd0);
    chk("to_err", {29'd0, last_err}, 32'd5);
    chk("to_delay", 32'((done_t - 5 - last_t) / 10), 32'd100);
    chk("to_busy", {31'd0, zif.busy}, 32'd0);
`else
    idle(150);
    chk("noto_no_done", done_cnt - d0, 32'd0);
    chk("noto_busy", {31'd0, zif.busy}, 32'd1);
    tx_q.push_back(8'h03); tx_q.push_back(8'h00);
    tx_q.push_back(8'h00); tx_q.push_back(8'h0A);
    send_q(1'b0);
    idle(3);
    chk("noto_done_cnt", done_cnt - d0, 32'd1);
    chk("noto_ok", {31'd0, last_ok}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
